keypad_scan: RTL and testbench

4x4 matrix keypad scanner and code-entry register. It is the input-side counterpart of the 7-segment display driver. It drives keypad columns, samples and debounces the rows, and decodes each press to a 4-bit key code. Digit keys are accumulated into a 4-digit BCD word that feeds the display driver's data input and the code comparator. Single clock domain: scan timing uses a clock-enable tick, never a derived clock.

---
 rtl/keypad_pkg.sv | 48 ++++
 rtl/code_entry_reg.sv | 52 +++++
 rtl/keypad_scan.sv | 170 +++++++++++++++++
 tb/tb_keypad_scan.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner: FSM encodings, key map and
// row decode helpers used by the scanner and the code-entry register.
package keypad_pkg;

  localparam int unsigned ROWS       = 4;
  localparam int unsigned COLS       = 4;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned DIGITS_W   = CODE_W * MAX_DIGITS;
  localparam int unsigned CNT_W      = 3;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam logic [CODE_W-1:0] KEY_BKSP  = 4'hB;
  localparam logic [CODE_W-1:0] KEY_CLR   = 4'hC;
  localparam logic [CODE_W-1:0] KEY_ENTER = 4'hE;

  // Nibble at index {row,col}: rows are 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [ROWS*COLS*CODE_W-1:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [1:0] row_index(input logic [ROWS-1:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    case (rows_n)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [CODE_W-1:0] key_lookup(input logic [1:0] row,
                                                    input logic [1:0] col);
    logic [5:0] base;
    base = {row, col, 2'b00};
    return KEY_MAP[base +: CODE_W];
  endfunction

  function automatic logic single_row_low(input logic [ROWS-1:0] rows_n);
    return $onehot(~rows_n);
  endfunction

endpackage

// File: rtl/code_entry_reg.sv
// Accumulates accepted digit keys into a 4-digit BCD word and handles
// backspace, clear and enter keys.
module code_entry_reg
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [CODE_W-1:0]   key_code,
  output logic [DIGITS_W-1:0] digits,
  output logic [CNT_W-1:0]    digit_cnt,
  output logic                enter
);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(MAX_DIGITS);
  localparam logic [CODE_W-1:0] DIGIT_MAX = CODE_W'(9);

  always_ff @(posedge clk) begin
    if (!rst) begin
      digits    <= '0;
      digit_cnt <= '0;
      enter     <= 1'b0;
    end else begin
      enter <= 1'b0;
      if (key_valid) begin
        if (key_code <= DIGIT_MAX) begin
          // A full entry silently drops further digits
          if (digit_cnt < CNT_FULL) begin
            digits    <= {digits[DIGITS_W-CODE_W-1:0], key_code};
            digit_cnt <= digit_cnt + CNT_W'(1);
          end
        end else begin
          case (key_code)
            KEY_BKSP: begin
              digits <= {CODE_W'(0), digits[DIGITS_W-1:CODE_W]};
              if (digit_cnt != '0) begin
                digit_cnt <= digit_cnt - CNT_W'(1);
              end
            end
            KEY_CLR: begin
              digits    <= '0;
              digit_cnt <= '0;
            end
            KEY_ENTER: enter <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with row synchroniser, tick-based debounce and
// one-shot press detection feeding the code-entry register.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [ROWS-1:0]     row_in,
  output logic [COLS-1:0]     col_out,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_code,
  output logic [DIGITS_W-1:0] digits,
  output logic [CNT_W-1:0]    digit_cnt,
  output logic                enter
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_TICKS - 1);

  logic [ROWS-1:0]   row_meta;
  logic [ROWS-1:0]   row_sync;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [DB_W-1:0]   db_cnt;
  logic [DB_W-1:0]   db_cnt_nx;
  logic [1:0]        col_idx;
  logic [1:0]        col_nx;
  logic [ROWS-1:0]   row_lat;
  logic [ROWS-1:0]   row_lat_nx;
  logic              press_c;
  logic [CODE_W-1:0] code_c;

  // Rows are asynchronous to clk
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // Scan tick divider, parked while disabled
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!en || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = en && (div_cnt == DIV_LAST);

  // Next-state logic for the scan / debounce / release sequence
  always_comb begin
    state_nx   = state;
    db_cnt_nx  = db_cnt;
    col_nx     = col_idx;
    row_lat_nx = row_lat;
    press_c    = 1'b0;
    code_c     = key_lookup(row_index(row_lat), col_idx);

    if (!en) begin
      state_nx  = ST_SCAN;
      db_cnt_nx = '0;
      col_nx    = 2'd0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (tick) begin
            if (single_row_low(row_sync)) begin
              row_lat_nx = row_sync;
              db_cnt_nx  = DB_W'(1);
              state_nx   = ST_DEBOUNCE;
            end else begin
              col_nx = col_idx + 2'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (tick) begin
            // row_lat is one-hot-zero, so equality also rejects multi-row
            if (row_sync == row_lat) begin
              if (db_cnt >= DB_LAST) begin
                db_cnt_nx = '0;
                state_nx  = ST_PRESSED;
                press_c   = 1'b1;
              end else begin
                db_cnt_nx = db_cnt + DB_W'(1);
              end
            end else begin
              db_cnt_nx = '0;
              col_nx    = col_idx + 2'd1;
              state_nx  = ST_SCAN;
            end
          end
        end
        ST_PRESSED: begin
          db_cnt_nx = '0;
          state_nx  = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (tick) begin
            if (row_sync == '1) begin
              if (db_cnt >= DB_LAST) begin
                db_cnt_nx = '0;
                col_nx    = col_idx + 2'd1;
                state_nx  = ST_SCAN;
              end else begin
                db_cnt_nx = db_cnt + DB_W'(1);
              end
            end else begin
              db_cnt_nx = '0;
            end
          end
        end
        default: begin
          state_nx  = ST_SCAN;
          db_cnt_nx = '0;
        end
      endcase
    end
  end

  // key_valid rises on the same edge that enters PRESSED
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_SCAN;
      db_cnt    <= '0;
      col_idx   <= 2'd0;
      row_lat   <= '1;
      col_out   <= 4'b1110;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      state     <= state_nx;
      db_cnt    <= db_cnt_nx;
      col_idx   <= col_nx;
      row_lat   <= row_lat_nx;
      col_out   <= en ? ~(COLS'(1) << col_nx) : '1;
      key_valid <= press_c;
      if (press_c) begin
        key_code <= code_c;
      end
    end
  end

  code_entry_reg u_code_entry (
    .clk       (clk),
    .rst       (rst),
    .key_valid (press_c),
    .key_code  (code_c),
    .digits    (digits),
    .digit_cnt (digit_cnt),
    .enter     (enter)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model drives rows from col_out,
// expected key events are queued at press time and popped on key_valid.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;
  logic        enter;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_TICKS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digits    (digits),
    .digit_cnt (digit_cnt),
    .enter     (enter)
  );

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] digits;
    logic [2:0]  cnt;
    logic        enter;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          kv_seen  = 0;
  int          n_pushed = 0;
  logic        key_on, key2_on;
  logic [1:0]  key_r, key_c, key2_r, key2_c;
  logic [15:0] m_digits;
  logic [2:0]  m_cnt;

  // Keypad: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row_in = 4'hF;
    if (key_on && !col_out[key_c])   row_in[key_r]  = 1'b0;
    if (key2_on && !col_out[key2_c]) row_in[key2_r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] tb_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] t [16];
    t = '{4'h1, 4'h2, 4'h3, 4'hA,
          4'h4, 4'h5, 4'h6, 4'hB,
          4'h7, 4'h8, 4'h9, 4'hC,
          4'hE, 4'h0, 4'hF, 4'hD};
    return t[{r, c}];
  endfunction

  task automatic push_expect(input logic [3:0] code);
    exp_t e;
    logic ent;
    ent = 1'b0;
    if (code <= 4'd9) begin
      if (m_cnt < 3'd4) begin
        m_digits = {m_digits[11:0], code};
        m_cnt    = m_cnt + 3'd1;
      end
    end else if (code == 4'hB) begin
      m_digits = {4'h0, m_digits[15:4]};
      if (m_cnt != 3'd0) m_cnt = m_cnt - 3'd1;
    end else if (code == 4'hC) begin
      m_digits = 16'h0;
      m_cnt    = 3'd0;
    end else if (code == 4'hE) begin
      ent = 1'b1;
    end
    e = '{code: code, digits: m_digits, cnt: m_cnt, enter: ent};
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic wait_kv();
    int waited;
    waited = 0;
    while (!key_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("kv_timeout", 32'(key_valid), 32'd1);
  endtask

  task automatic press_key(input logic [1:0] r, input logic [1:0] c);
    push_expect(tb_code(r, c));
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
    wait_kv();
    repeat (24) @(negedge clk);
    key_on = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  // Scoreboard monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (key_valid) begin
        kv_seen++;
        check("kv_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e_mon = exp_q.pop_front();
          check("key_code", 32'(key_code), 32'(e_mon.code));
          check("digits", 32'(digits), 32'(e_mon.digits));
          check("digit_cnt", 32'(digit_cnt), 32'(e_mon.cnt));
          check("enter", 32'(enter), 32'(e_mon.enter));
        end
      end else if (enter) begin
        check("enter_stray", 32'(enter), 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] col_seq [4];
    int kv_before;
    int waited;
    col_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst = 1'b0; en = 1'b1; key_on = 1'b0; key2_on = 1'b0;
    key_r = 2'd0; key_c = 2'd0; key2_r = 2'd0; key2_c = 2'd0;
    m_digits = 16'h0; m_cnt = 3'd0;

    repeat (3) @(negedge clk);
    check("rst_col_out", 32'(col_out), 32'(4'b1110));
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_digit_cnt", 32'(digit_cnt), 32'd0);
    check("rst_enter", 32'(enter), 32'd0);

    // Idle scan: column advances every 4 clocks
    rst = 1'b1;
    @(negedge clk);
    check("scan_col0", 32'(col_out), 32'(4'b1110));
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      check("scan_col_seq", 32'(col_out), 32'(col_seq[i]));
    end

    // Single press of "6"
    press_key(2'd1, 2'd2);
    check("six_digits", 32'(digits), 32'h0006);
    check("six_cnt", 32'(digit_cnt), 32'd1);

    // Clear, then fill past capacity, then backspace
    press_key(2'd2, 2'd3);
    press_key(2'd0, 2'd0);
    press_key(2'd0, 2'd1);
    press_key(2'd0, 2'd2);
    press_key(2'd1, 2'd0);
    check("full_digits", 32'(digits), 32'h1234);
    check("full_cnt", 32'(digit_cnt), 32'd4);
    press_key(2'd1, 2'd1);
    check("overflow_digits", 32'(digits), 32'h1234);
    press_key(2'd1, 2'd3);
    check("bksp_digits", 32'(digits), 32'h0123);
    check("bksp_cnt", 32'(digit_cnt), 32'd3);

    // Two-tick glitch on r0c0 aligned to column 0
    waited = 0;
    while (col_out != 4'b1110 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("glitch_align", 32'(col_out), 32'(4'b1110));
    kv_before = kv_seen;
    key_r = 2'd0; key_c = 2'd0; key_on = 1'b1;
    repeat (8) @(negedge clk);
    key_on = 1'b0;
    repeat (60) @(negedge clk);
    check("glitch_no_kv", 32'(kv_seen), 32'(kv_before));

    // Two rows low in the same column
    key_r = 2'd0; key_c = 2'd1; key2_r = 2'd1; key2_c = 2'd1;
    key_on = 1'b1; key2_on = 1'b1;
    repeat (100) @(negedge clk);
    key_on = 1'b0; key2_on = 1'b0;
    repeat (40) @(negedge clk);
    check("multirow_no_kv", 32'(kv_seen), 32'(kv_before));

    // Clear, enter 9 8, then Enter and Clear
    press_key(2'd2, 2'd3);
    press_key(2'd2, 2'd2);
    press_key(2'd2, 2'd1);
    press_key(2'd3, 2'd0);
    check("enter_digits", 32'(digits), 32'h0098);
    press_key(2'd2, 2'd3);
    check("clr_digits", 32'(digits), 32'h0000);
    check("clr_cnt", 32'(digit_cnt), 32'd0);

    // Drop enable while the "7" key is still held in release
    push_expect(tb_code(2'd2, 2'd0));
    key_r = 2'd2; key_c = 2'd0; key_on = 1'b1;
    wait_kv();
    repeat (3) @(negedge clk);
    kv_before = kv_seen;
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("dis_col_out", 32'(col_out), 32'(4'b1111));
    repeat (40) @(negedge clk);
    check("dis_col_hold", 32'(col_out), 32'(4'b1111));
    key_on = 1'b0;
    repeat (10) @(negedge clk);
    check("dis_no_kv", 32'(kv_seen), 32'(kv_before));
    en = 1'b1;
    @(negedge clk);
    check("reen_col0", 32'(col_out), 32'(4'b1110));
    check("reen_digits", 32'(digits), 32'h0007);
    check("reen_cnt", 32'(digit_cnt), 32'd1);
    press_key(2'd0, 2'd2);
    check("reen_press", 32'(digits), 32'h0073);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("kv_total", 32'(kv_seen), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
